// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle controller and its datapath: FSM states,
// opcodes, and the select codes for every datapath mux.
package mc_controller_pkg;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StPcInc,
        StDecode,
        StAluR,
        StAdi,
        StLhi,
        StLw,
        StSw,
        StLm,
        StSm,
        StBeq,
        StBr,
        StJal1,
        StJal2
    } mc_state_e;

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpAdi  = 4'b0001;
    localparam logic [3:0] OpNand = 4'b0010;
    localparam logic [3:0] OpLhi  = 4'b0011;
    localparam logic [3:0] OpLw   = 4'b0100;
    localparam logic [3:0] OpSw   = 4'b0101;
    localparam logic [3:0] OpLm   = 4'b0110;
    localparam logic [3:0] OpSm   = 4'b0111;
    localparam logic [3:0] OpJal  = 4'b1000;
    localparam logic [3:0] OpBeq  = 4'b1100;

    // Mux1: ALU operand B
    localparam logic [2:0] AluBZero = 3'd0;
    localparam logic [2:0] AluBOne  = 3'd1;
    localparam logic [2:0] AluBRegB = 3'd2;
    localparam logic [2:0] AluBImm6 = 3'd3;
    localparam logic [2:0] AluBCnt  = 3'd4;

    // Mux2: ALU operand A
    localparam logic [2:0] AluAZero   = 3'd0;
    localparam logic [2:0] AluAOne    = 3'd1;
    localparam logic [2:0] AluAShift7 = 3'd2;
    localparam logic [2:0] AluAImm6   = 3'd3;
    localparam logic [2:0] AluAImm9   = 3'd4;
    localparam logic [2:0] AluARegA   = 3'd5;
    localparam logic [2:0] AluATmpA   = 3'd6;

    // Mux3: RF write enable
    localparam logic [1:0] RfWenOff  = 2'd0;
    localparam logic [1:0] RfWenOn   = 2'd1;
    localparam logic [1:0] RfWenCz   = 2'd2;
    localparam logic [1:0] RfWenMask = 2'd3;

    // Mux4: RF write address (Ra=IR[11:9], Rb=IR[8:6], Rc=IR[5:3])
    localparam logic [2:0] RfWaddRa  = 3'd0;
    localparam logic [2:0] RfWaddRc  = 3'd1;
    localparam logic [2:0] RfWaddCnt = 3'd2;
    localparam logic [2:0] RfWaddR7  = 3'd3;
    localparam logic [2:0] RfWaddRb  = 3'd4;

    // Mux5: RF second read port
    localparam logic [1:0] RfRd2Rb  = 2'd0;
    localparam logic [1:0] RfRd2Cnt = 2'd1;
    localparam logic [1:0] RfRd2R7  = 2'd2;

    localparam logic RfDinMem = 1'b0;
    localparam logic RfDinT1  = 1'b1;

    localparam logic [1:0] MemWrOff  = 2'd0;
    localparam logic [1:0] MemWrOn   = 2'd1;
    localparam logic [1:0] MemWrMask = 2'd2;

    localparam logic MemDinA = 1'b0;
    localparam logic MemDinB = 1'b1;

    localparam logic AluOpAdd  = 1'b0;
    localparam logic AluOpNand = 1'b1;

    typedef struct packed {
        logic [2:0] mux1;
        logic [2:0] mux2;
        logic [1:0] mux3;
        logic [2:0] mux4;
        logic [1:0] mux5;
        logic       mux6;
        logic [1:0] mux8;
        logic       mux9;
        logic       cz_en;
        logic       alu_op;
        logic       mem_read;
        logic       w_ir;
        logic       w_atmp;
        logic       reset_t1;
    } mc_outs_t;

    // Execute state reached from decode; unknown opcodes behave as NOP.
    function automatic mc_state_e dispatch(input logic [3:0] op);
        mc_state_e st;
        case (op)
            OpAdd, OpNand: st = StAluR;
            OpAdi:         st = StAdi;
            OpLhi:         st = StLhi;
            OpLw:          st = StLw;
            OpSw:          st = StSw;
            OpLm:          st = StLm;
            OpSm:          st = StSm;
            OpBeq:         st = StBeq;
            OpJal:         st = StJal1;
            default:       st = StFetch;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath signal bundle: opcode/compare in, selects and strobes out.
interface mc_if;
    import mc_controller_pkg::*;

    logic [3:0]       opcode;
    logic             compare;
    logic [2:0]       Mux1_alu_B;
    logic [2:0]       Mux2_alu_A;
    logic [1:0]       Mux3_RF_wen;
    logic [2:0]       Mux4_RF_wadd;
    logic [1:0]       Mux5_RF_read2;
    logic             Mux6_RF_dataIn;
    logic [1:0]       Mux8_memwrite;
    logic             Mux9_memDataIn;
    logic             CZ_en;
    logic             ALU_op;
    logic             memRead;
    logic             wIR;
    logic             wAtmp;
    logic             resetT1;
    logic [CNT_W-1:0] counter;

    modport ctrl (
        input  opcode, compare,
        output Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
               Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op,
               memRead, wIR, wAtmp, resetT1, counter
    );

    modport dp (
        output opcode, compare,
        input  Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
               Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op,
               memRead, wIR, wAtmp, resetT1, counter
    );

endinterface

// File: rtl/mc_out_decode.sv
// Combinational map from FSM state and opcode to every datapath select and strobe.
module mc_out_decode
    import mc_controller_pkg::*;
(
    input  mc_state_e  state_i,
    input  logic [3:0] opcode_i,
    output mc_outs_t   outs_o
);

    always_comb begin
        outs_o = '0;
        unique case (state_i)
            StIdle: begin
                outs_o.reset_t1 = 1'b1;
            end
            StFetch: begin
                outs_o.mux5     = RfRd2R7;
                outs_o.mux2     = AluAZero;
                outs_o.mux1     = AluBRegB;
                outs_o.mem_read = 1'b1;
                outs_o.w_ir     = 1'b1;
            end
            StPcInc: begin
                outs_o.mux2 = AluAOne;
                outs_o.mux1 = AluBRegB;
                outs_o.mux5 = RfRd2R7;
                outs_o.mux4 = RfWaddR7;
                outs_o.mux6 = RfDinT1;
                outs_o.mux3 = RfWenOn;
            end
            StDecode: begin
                outs_o.w_atmp = 1'b1;
            end
            StAluR: begin
                outs_o.mux2   = AluARegA;
                outs_o.mux1   = AluBRegB;
                outs_o.mux5   = RfRd2Rb;
                // ALUR is only entered for ADD and NAND
                outs_o.alu_op = (opcode_i == OpNand) ? AluOpNand : AluOpAdd;
                outs_o.cz_en  = 1'b1;
                outs_o.mux4   = RfWaddRc;
                outs_o.mux6   = RfDinT1;
                outs_o.mux3   = RfWenCz;
            end
            StAdi: begin
                outs_o.mux2  = AluARegA;
                outs_o.mux1  = AluBImm6;
                outs_o.cz_en = 1'b1;
                outs_o.mux4  = RfWaddRb;
                outs_o.mux6  = RfDinT1;
                outs_o.mux3  = RfWenOn;
            end
            StLhi: begin
                outs_o.mux2 = AluAShift7;
                outs_o.mux1 = AluBZero;
                outs_o.mux4 = RfWaddRa;
                outs_o.mux6 = RfDinT1;
                outs_o.mux3 = RfWenOn;
            end
            StLw: begin
                outs_o.mux2     = AluAImm6;
                outs_o.mux1     = AluBRegB;
                outs_o.mux5     = RfRd2Rb;
                outs_o.mem_read = 1'b1;
                outs_o.mux6     = RfDinMem;
                outs_o.mux4     = RfWaddRa;
                outs_o.mux3     = RfWenOn;
            end
            StSw: begin
                outs_o.mux2 = AluAImm6;
                outs_o.mux1 = AluBRegB;
                outs_o.mux5 = RfRd2Rb;
                outs_o.mux8 = MemWrOn;
                outs_o.mux9 = MemDinA;
            end
            StLm: begin
                outs_o.mux2     = AluATmpA;
                outs_o.mux1     = AluBCnt;
                outs_o.mem_read = 1'b1;
                outs_o.mux6     = RfDinMem;
                outs_o.mux4     = RfWaddCnt;
                outs_o.mux3     = RfWenMask;
            end
            StSm: begin
                outs_o.mux2 = AluATmpA;
                outs_o.mux1 = AluBCnt;
                outs_o.mux5 = RfRd2Cnt;
                outs_o.mux9 = MemDinB;
                outs_o.mux8 = MemWrMask;
            end
            StBeq: begin
                outs_o.mux2 = AluARegA;
                outs_o.mux1 = AluBRegB;
                outs_o.mux5 = RfRd2Rb;
            end
            StBr: begin
                outs_o.mux2 = AluAImm6;
                outs_o.mux1 = AluBRegB;
                outs_o.mux5 = RfRd2R7;
                outs_o.mux4 = RfWaddR7;
                outs_o.mux6 = RfDinT1;
                outs_o.mux3 = RfWenOn;
            end
            StJal1: begin
                outs_o.mux2 = AluAZero;
                outs_o.mux1 = AluBRegB;
                outs_o.mux5 = RfRd2R7;
                outs_o.mux4 = RfWaddRa;
                outs_o.mux6 = RfDinT1;
                outs_o.mux3 = RfWenOn;
            end
            StJal2: begin
                outs_o.mux2 = AluAImm9;
                outs_o.mux1 = AluBRegB;
                outs_o.mux5 = RfRd2R7;
                outs_o.mux4 = RfWaddR7;
                outs_o.mux6 = RfDinT1;
                outs_o.mux3 = RfWenOn;
            end
            default: begin
                outs_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: state register, LM/SM counter and registered datapath controls.
module mc_controller
    import mc_controller_pkg::*;
(
    input logic clk,
    input logic reset_n,
    mc_if.ctrl  bus
);

    localparam logic [CNT_W-1:0] CntLast = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    mc_outs_t         outs_q, outs_d;

    always_comb begin
        state_d   = state_q;
        counter_d = '0;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  state_d = StPcInc;
            StPcInc:  state_d = StDecode;
            StDecode: state_d = dispatch(bus.opcode);
            StAluR, StAdi, StLhi, StLw, StSw, StBr, StJal2: begin
                state_d = StFetch;
            end
            StLm, StSm: begin
                // Counter wraps to 0 on the same edge that leaves for fetch
                counter_d = counter_q + CntOne;
                if (counter_q == CntLast) begin
                    state_d = StFetch;
                end
            end
            StBeq:    state_d = bus.compare ? StBr : StFetch;
            StJal1:   state_d = StJal2;
            default:  state_d = StIdle;
        endcase
    end

    // Decoding the next state lets the controls be registered without adding latency.
    mc_out_decode u_out_decode (
        .state_i  (state_d),
        .opcode_i (bus.opcode),
        .outs_o   (outs_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            counter_q       <= '0;
            outs_q          <= '0;
            outs_q.reset_t1 <= 1'b1;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            outs_q    <= outs_d;
        end
    end

    assign bus.Mux1_alu_B     = outs_q.mux1;
    assign bus.Mux2_alu_A     = outs_q.mux2;
    assign bus.Mux3_RF_wen    = outs_q.mux3;
    assign bus.Mux4_RF_wadd   = outs_q.mux4;
    assign bus.Mux5_RF_read2  = outs_q.mux5;
    assign bus.Mux6_RF_dataIn = outs_q.mux6;
    assign bus.Mux8_memwrite  = outs_q.mux8;
    assign bus.Mux9_memDataIn = outs_q.mux9;
    assign bus.CZ_en          = outs_q.cz_en;
    assign bus.ALU_op         = outs_q.alu_op;
    assign bus.memRead        = outs_q.mem_read;
    assign bus.wIR            = outs_q.w_ir;
    assign bus.wAtmp          = outs_q.w_atmp;
    assign bus.resetT1        = outs_q.reset_t1;
    assign bus.counter        = counter_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-cycle control vectors compared against an instruction-level
// model that lists the expected control pattern of each cycle of an instruction.
module tb_mc_controller;

    typedef logic [25:0] vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t exp_q[$];
    vec_t obs_q[$];

    mc_if bus ();

    mc_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Field order: Mux1 Mux2 Mux3 Mux4 Mux5 Mux6 Mux8 Mux9 CZ ALUop memRead wIR wAtmp resetT1 cnt
    function automatic vec_t mk(input int m1, m2, m3, m4, m5, m6, m8, m9, cz, aop, mr, wir, wat,
                                rt1, cnt);
        return {3'(m1), 3'(m2), 2'(m3), 3'(m4), 2'(m5), 1'(m6), 2'(m8), 1'(m9), 1'(cz),
                1'(aop), 1'(mr), 1'(wir), 1'(wat), 1'(rt1), 3'(cnt)};
    endfunction

    function automatic vec_t v_idle();   return mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0); endfunction
    function automatic vec_t v_fetch();  return mk(2,0,0,0,2,0,0,0,0,0,1,1,0,0,0); endfunction
    function automatic vec_t v_pcinc();  return mk(2,1,1,3,2,1,0,0,0,0,0,0,0,0,0); endfunction
    function automatic vec_t v_decode(); return mk(0,0,0,0,0,0,0,0,0,0,0,0,1,0,0); endfunction
    function automatic vec_t v_alur(input int aop);
        return mk(2,5,2,1,0,1,0,0,1,aop,0,0,0,0,0);
    endfunction
    function automatic vec_t v_adi();    return mk(3,5,1,4,0,1,0,0,1,0,0,0,0,0,0); endfunction
    function automatic vec_t v_lhi();    return mk(0,2,1,0,0,1,0,0,0,0,0,0,0,0,0); endfunction
    function automatic vec_t v_lw();     return mk(2,3,1,0,0,0,0,0,0,0,1,0,0,0,0); endfunction
    function automatic vec_t v_sw();     return mk(2,3,0,0,0,0,1,0,0,0,0,0,0,0,0); endfunction
    function automatic vec_t v_lm(input int c); return mk(4,6,3,2,0,0,0,0,0,0,1,0,0,0,c); endfunction
    function automatic vec_t v_sm(input int c); return mk(4,6,0,0,1,0,2,1,0,0,0,0,0,0,c); endfunction
    function automatic vec_t v_beq();    return mk(2,5,0,0,0,0,0,0,0,0,0,0,0,0,0); endfunction
    function automatic vec_t v_br();     return mk(2,3,1,3,2,1,0,0,0,0,0,0,0,0,0); endfunction
    function automatic vec_t v_jal1();   return mk(2,0,1,0,2,1,0,0,0,0,0,0,0,0,0); endfunction
    function automatic vec_t v_jal2();   return mk(2,4,1,3,2,1,0,0,0,0,0,0,0,0,0); endfunction

    function automatic vec_t cur_vec();
        return {bus.Mux1_alu_B, bus.Mux2_alu_A, bus.Mux3_RF_wen, bus.Mux4_RF_wadd,
                bus.Mux5_RF_read2, bus.Mux6_RF_dataIn, bus.Mux8_memwrite, bus.Mux9_memDataIn,
                bus.CZ_en, bus.ALU_op, bus.memRead, bus.wIR, bus.wAtmp, bus.resetT1,
                bus.counter};
    endfunction

    // Instruction-level model: fetch, PC increment, decode, then the opcode's execute cycles.
    task automatic build_expected(input logic [3:0] op, input logic cmp);
        exp_q.delete();
        exp_q.push_back(v_fetch());
        exp_q.push_back(v_pcinc());
        exp_q.push_back(v_decode());
        case (op)
            4'b0000: exp_q.push_back(v_alur(0));
            4'b0010: exp_q.push_back(v_alur(1));
            4'b0001: exp_q.push_back(v_adi());
            4'b0011: exp_q.push_back(v_lhi());
            4'b0100: exp_q.push_back(v_lw());
            4'b0101: exp_q.push_back(v_sw());
            4'b0110: for (int c = 0; c < 8; c++) exp_q.push_back(v_lm(c));
            4'b0111: for (int c = 0; c < 8; c++) exp_q.push_back(v_sm(c));
            4'b1100: begin
                exp_q.push_back(v_beq());
                if (cmp) exp_q.push_back(v_br());
            end
            4'b1000: begin
                exp_q.push_back(v_jal1());
                exp_q.push_back(v_jal2());
            end
            default: ;
        endcase
    endtask

    // Entered at a falling edge inside a fetch cycle; returns at the next fetch cycle.
    task automatic run_instr(input logic [3:0] op, input logic cmp);
        build_expected(op, cmp);
        obs_q.delete();
        bus.opcode  = op;
        bus.compare = cmp;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i != 0) @(negedge clk);
            obs_q.push_back(cur_vec());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.opcode  = 4'b0000;
        bus.compare = 1'b0;
        reset_n     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (cur_vec() !== v_idle()) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, cur_vec(), v_idle());
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cur_vec() !== v_fetch()) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", cur_vec(), v_fetch());
        end
    endtask

    task automatic test_alu();
        logic [3:0] ops [2];
        ops[0] = 4'b0000;
        ops[1] = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            run_instr(ops[k], 1'b0);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL alu op=%b step %0d: got %h expected %h", ops[k], i,
                             obs_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (cur_vec() !== v_fetch()) begin
                n_fail++;
                $display("FAIL alu_return op=%b: got %h expected %h", ops[k], cur_vec(),
                         v_fetch());
            end
        end
    endtask

    task automatic test_lm_sm();
        for (int k = 0; k < 2; k++) begin
            run_instr((k == 0) ? 4'b0110 : 4'b0111, 1'b0);
            n_checks++;
            if (exp_q.size() != 11) begin
                n_fail++;
                $display("FAIL lmsm_len: got %0d expected 11", exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL lmsm k=%0d step %0d: got %h expected %h", k, i, obs_q[i],
                             exp_q[i]);
                end
            end
            n_checks++;
            if (cur_vec() !== v_fetch()) begin
                n_fail++;
                $display("FAIL lmsm_return k=%0d: got %h expected %h", k, cur_vec(), v_fetch());
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [3:0] ops [3];
        logic       cmps [3];
        ops[0] = 4'b1100; cmps[0] = 1'b0;
        ops[1] = 4'b1100; cmps[1] = 1'b1;
        ops[2] = 4'b1000; cmps[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_instr(ops[k], cmps[k]);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL brjmp op=%b cmp=%b step %0d: got %h expected %h", ops[k],
                             cmps[k], i, obs_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (cur_vec() !== v_fetch()) begin
                n_fail++;
                $display("FAIL brjmp_return op=%b: got %h expected %h", ops[k], cur_vec(),
                         v_fetch());
            end
        end
    endtask

    task automatic test_nop();
        logic [3:0] op;
        for (int k = 9; k < 16; k++) begin
            if (k == 12) continue;
            op = 4'(k);
            run_instr(op, 1'b1);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL nop op=%b step %0d: got %h expected %h", op, i, obs_q[i],
                             exp_q[i]);
                end
            end
            n_checks++;
            if (cur_vec() !== v_fetch()) begin
                n_fail++;
                $display("FAIL nop_return op=%b: got %h expected %h", op, cur_vec(), v_fetch());
            end
        end
    endtask

    task automatic test_reset_mid_lm();
        build_expected(4'b0110, 1'b0);
        bus.opcode = 4'b0110;
        for (int i = 0; i < 7; i++) begin
            if (i != 0) @(negedge clk);
            n_checks++;
            if (cur_vec() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midlm step %0d: got %h expected %h", i, cur_vec(), exp_q[i]);
            end
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (cur_vec() !== v_idle()) begin
            n_fail++;
            $display("FAIL midlm_async_reset: got %h expected %h", cur_vec(), v_idle());
        end
        @(negedge clk);
        n_checks++;
        if (cur_vec() !== v_idle()) begin
            n_fail++;
            $display("FAIL midlm_reset_hold: got %h expected %h", cur_vec(), v_idle());
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cur_vec() !== v_fetch()) begin
            n_fail++;
            $display("FAIL midlm_release: got %h expected %h", cur_vec(), v_fetch());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        logic       cmp;
        for (int n = 0; n < 200; n++) begin
            op  = 4'($urandom_range(0, 15));
            cmp = 1'($urandom_range(0, 1));
            run_instr(op, cmp);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand n=%0d op=%b cmp=%b step %0d: got %h expected %h", n, op,
                             cmp, i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (cur_vec() !== v_fetch()) begin
            n_fail++;
            $display("FAIL rand_return: got %h expected %h", cur_vec(), v_fetch());
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lm_sm();
        test_branch_jump();
        test_nop();
        test_reset_mid_lm();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
